// File: rtl/mem_arb2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb2_pkg
// Description : Shared memory-system constants (return tags, burst length,
//               arbiter owner encodings) used by mem_arb2 and the SRAM ctrl.
// Revision    : 1.0
// ============================================================================
package mem_arb2_pkg;

    localparam int c_burst_length = 4;
    localparam int c_max_outst    = 2;

    // Return tag 0 is reserved for "no data on s_readdata this cycle"
    localparam logic [1:0] c_id_none = 2'd0;
    localparam logic [1:0] c_id_a    = 2'd1;
    localparam logic [1:0] c_id_b    = 2'd2;

    localparam int                 c_own_w    = 2;
    localparam logic [c_own_w-1:0] c_own_none = 2'd0;
    localparam logic [c_own_w-1:0] c_own_a    = 2'd1;
    localparam logic [c_own_w-1:0] c_own_b    = 2'd2;

endpackage
`default_nettype wire

// File: rtl/mem_arb2_burst_tracker.sv
`default_nettype none
// ============================================================================
// Module      : burst_tracker
// Description : Per-master read bookkeeping: words received in the current
//               burst and number of unfinished bursts.
// Revision    : 1.0
// ============================================================================
module burst_tracker #(
    parameter int BURST_LENGTH = 4,
    parameter int MAX_OUTST    = 2
) (
    input  logic clock,
    input  logic rst,
    input  logic issue,
    input  logic ret_valid,
    output logic ret_busy
);

    localparam int c_wcnt_w  = (BURST_LENGTH > 1) ? $clog2(BURST_LENGTH) : 1;
    localparam int c_outst_w = $clog2(MAX_OUTST + 1);

    localparam logic [c_wcnt_w-1:0]  c_wcnt_last = c_wcnt_w'(BURST_LENGTH - 1);
    localparam logic [c_wcnt_w-1:0]  c_wcnt_one  = c_wcnt_w'(1);
    localparam logic [c_outst_w-1:0] c_outst_max = c_outst_w'(MAX_OUTST);
    localparam logic [c_outst_w-1:0] c_outst_one = c_outst_w'(1);

    logic [c_wcnt_w-1:0]  r_wcnt;
    logic [c_outst_w-1:0] r_outst;
    logic                 w_count;
    logic                 w_done;

    // Words arriving with nothing outstanding are strays; never let them
    // advance the word counter or drive outst below zero.
    assign w_count  = ret_valid && (r_outst != '0);
    assign w_done   = w_count && (r_wcnt == c_wcnt_last);
    assign ret_busy = (r_outst == c_outst_max);

    always_ff @(posedge clock) begin
        if (rst) begin
            r_wcnt  <= '0;
            r_outst <= '0;
        end else begin
            if (w_count) begin
                r_wcnt <= w_done ? '0 : (r_wcnt + c_wcnt_one);
            end
            if (issue && !w_done && (r_outst != c_outst_max)) begin
                r_outst <= r_outst + c_outst_one;
            end else if (w_done && !issue) begin
                r_outst <= r_outst - c_outst_one;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!rst) begin
            assert (!(ret_valid && (r_outst == '0)))
            else $error("burst_tracker: read return with no burst outstanding");
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arb2.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb2
// Description : Two-master round-robin arbiter in front of an SRAM controller
//               with tagged, burst-oriented read returns.
// Revision    : 1.0
// ============================================================================
module mem_arb2
    import mem_arb2_pkg::*;
#(
    parameter int         BURST_LENGTH = c_burst_length,
    parameter int         MAX_OUTST    = c_max_outst,
    parameter logic [1:0] ID_A         = c_id_a,
    parameter logic [1:0] ID_B         = c_id_b
) (
    input  logic        clock,
    input  logic        rst,

    input  logic [29:0] ma_address,
    input  logic        ma_read,
    input  logic        ma_write,
    input  logic [31:0] ma_writedata,
    input  logic [3:0]  ma_writedatamask,
    output logic        ma_waitrequest,
    output logic [31:0] ma_readdata,
    output logic        ma_readdatavalid,

    input  logic [29:0] mb_address,
    input  logic        mb_read,
    input  logic        mb_write,
    input  logic [31:0] mb_writedata,
    input  logic [3:0]  mb_writedatamask,
    output logic        mb_waitrequest,
    output logic [31:0] mb_readdata,
    output logic        mb_readdatavalid,

    output logic [29:0] s_address,
    output logic        s_read,
    output logic        s_write,
    output logic [31:0] s_writedata,
    output logic [3:0]  s_writedatamask,
    output logic [1:0]  s_id,
    input  logic        s_waitrequest,
    input  logic [31:0] s_readdata,
    input  logic [1:0]  s_readdataid
);

    logic [c_own_w-1:0] r_owner;
    logic [c_own_w-1:0] r_last;
    logic [c_own_w-1:0] w_grant;
    logic [c_own_w-1:0] w_owner_nxt;
    logic [c_own_w-1:0] w_last_nxt;

    logic w_busy_a;
    logic w_busy_b;
    logic w_elig_a;
    logic w_elig_b;
    logic w_issue_a;
    logic w_issue_b;

    // Writes bypass the outstanding-read limit entirely
    assign w_elig_a = !rst && (ma_write || (ma_read && !w_busy_a));
    assign w_elig_b = !rst && (mb_write || (mb_read && !w_busy_b));

    always_ff @(posedge clock) begin
        if (rst) begin
            r_owner <= c_own_none;
            r_last  <= c_own_b;
        end else begin
            r_owner <= w_owner_nxt;
            r_last  <= w_last_nxt;
        end
    end

    always_comb begin
        w_grant         = r_owner;
        w_owner_nxt     = c_own_none;
        w_last_nxt      = r_last;
        s_address       = '0;
        s_read          = 1'b0;
        s_write         = 1'b0;
        s_writedata     = '0;
        s_writedatamask = '0;
        s_id            = c_id_none;

        if (rst) begin
            w_grant = c_own_none;
        end else if (r_owner == c_own_none) begin
            if (w_elig_a && w_elig_b) begin
                w_grant = (r_last == c_own_a) ? c_own_b : c_own_a;
            end else if (w_elig_a) begin
                w_grant = c_own_a;
            end else if (w_elig_b) begin
                w_grant = c_own_b;
            end
        end

        case (w_grant)
            c_own_a: begin
                s_address       = ma_address;
                s_read          = ma_read;
                s_write         = ma_write;
                s_writedata     = ma_writedata;
                s_writedatamask = ma_writedatamask;
                s_id            = ID_A;
            end
            c_own_b: begin
                s_address       = mb_address;
                s_read          = mb_read;
                s_write         = mb_write;
                s_writedata     = mb_writedata;
                s_writedatamask = mb_writedatamask;
                s_id            = ID_B;
            end
            default: ;
        endcase

        // Lock the grant only while a live request is stalled by the controller
        if ((w_grant != c_own_none) && (s_read || s_write)) begin
            if (s_waitrequest) begin
                w_owner_nxt = w_grant;
            end else begin
                w_last_nxt = w_grant;
            end
        end
    end

    assign ma_waitrequest = (w_grant == c_own_a) ? s_waitrequest : (ma_read || ma_write);
    assign mb_waitrequest = (w_grant == c_own_b) ? s_waitrequest : (mb_read || mb_write);

    assign w_issue_a = (w_grant == c_own_a) && s_read && !s_waitrequest;
    assign w_issue_b = (w_grant == c_own_b) && s_read && !s_waitrequest;

    assign ma_readdata      = s_readdata;
    assign mb_readdata      = s_readdata;
    assign ma_readdatavalid = !rst && (s_readdataid == ID_A);
    assign mb_readdatavalid = !rst && (s_readdataid == ID_B);

    burst_tracker #(
        .BURST_LENGTH (BURST_LENGTH),
        .MAX_OUTST    (MAX_OUTST)
    ) u_trk_a (
        .clock     (clock),
        .rst       (rst),
        .issue     (w_issue_a),
        .ret_valid (ma_readdatavalid),
        .ret_busy  (w_busy_a)
    );

    burst_tracker #(
        .BURST_LENGTH (BURST_LENGTH),
        .MAX_OUTST    (MAX_OUTST)
    ) u_trk_b (
        .clock     (clock),
        .rst       (rst),
        .issue     (w_issue_b),
        .ret_valid (mb_readdatavalid),
        .ret_busy  (w_busy_b)
    );

endmodule
`default_nettype wire

// File: tb/tb_mem_arb2.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arb2
// Description : Directed self-checking bench for mem_arb2; the SRAM controller
//               side is driven directly by the stimulus.
// Revision    : 1.0
// ============================================================================
module tb_mem_arb2;

    logic        clock;
    logic        rst;
    logic [29:0] ma_address;
    logic        ma_read;
    logic        ma_write;
    logic [31:0] ma_writedata;
    logic [3:0]  ma_writedatamask;
    logic        ma_waitrequest;
    logic [31:0] ma_readdata;
    logic        ma_readdatavalid;
    logic [29:0] mb_address;
    logic        mb_read;
    logic        mb_write;
    logic [31:0] mb_writedata;
    logic [3:0]  mb_writedatamask;
    logic        mb_waitrequest;
    logic [31:0] mb_readdata;
    logic        mb_readdatavalid;
    logic [29:0] s_address;
    logic        s_read;
    logic        s_write;
    logic [31:0] s_writedata;
    logic [3:0]  s_writedatamask;
    logic [1:0]  s_id;
    logic        s_waitrequest;
    logic [31:0] s_readdata;
    logic [1:0]  s_readdataid;

    int n_checks = 0;
    int n_errors = 0;

    mem_arb2 u_dut (
        .clock            (clock),
        .rst              (rst),
        .ma_address       (ma_address),
        .ma_read          (ma_read),
        .ma_write         (ma_write),
        .ma_writedata     (ma_writedata),
        .ma_writedatamask (ma_writedatamask),
        .ma_waitrequest   (ma_waitrequest),
        .ma_readdata      (ma_readdata),
        .ma_readdatavalid (ma_readdatavalid),
        .mb_address       (mb_address),
        .mb_read          (mb_read),
        .mb_write         (mb_write),
        .mb_writedata     (mb_writedata),
        .mb_writedatamask (mb_writedatamask),
        .mb_waitrequest   (mb_waitrequest),
        .mb_readdata      (mb_readdata),
        .mb_readdatavalid (mb_readdatavalid),
        .s_address        (s_address),
        .s_read           (s_read),
        .s_write          (s_write),
        .s_writedata      (s_writedata),
        .s_writedatamask  (s_writedatamask),
        .s_id             (s_id),
        .s_waitrequest    (s_waitrequest),
        .s_readdata       (s_readdata),
        .s_readdataid     (s_readdataid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Returns n words tagged id and checks they route only to the matching master
    task automatic ret_burst(input logic [1:0] id, input int n);
        logic [31:0] data;
        for (int i = 0; i < n; i++) begin
            data         = 32'hD000_0000 + (32'(id) << 8) + 32'(i);
            s_readdataid = id;
            s_readdata   = data;
            @(negedge clock);
            check("ret_rdv_a", 32'(ma_readdatavalid), 32'(id == 2'd1));
            check("ret_rdv_b", 32'(mb_readdatavalid), 32'(id == 2'd2));
            if (id == 2'd1) check("ret_data_a", ma_readdata, data);
            if (id == 2'd2) check("ret_data_b", mb_readdata, data);
            tick();
        end
        s_readdataid = 2'd0;
        s_readdata   = '0;
    endtask

    int cnt_a;
    int cnt_b;
    logic [1:0] exp_id;

    initial begin
        rst = 1'b1;
        ma_address = '0; ma_read = 1'b0; ma_write = 1'b0; ma_writedata = '0; ma_writedatamask = '0;
        mb_address = '0; mb_read = 1'b0; mb_write = 1'b0; mb_writedata = '0; mb_writedatamask = '0;
        s_waitrequest = 1'b0; s_readdata = '0; s_readdataid = 2'd0;
        tick();
        tick();

        // Requests and returns during reset must be suppressed
        ma_read = 1'b1; mb_write = 1'b1; s_readdataid = 2'd1;
        @(negedge clock);
        check("rst_s_read", 32'(s_read), 32'd0);
        check("rst_s_write", 32'(s_write), 32'd0);
        check("rst_rdv_a", 32'(ma_readdatavalid), 32'd0);
        tick();
        ma_read = 1'b0; mb_write = 1'b0; s_readdataid = 2'd0; rst = 1'b0;
        @(negedge clock);
        check("idle_wr_a", 32'(ma_waitrequest), 32'd0);
        check("idle_wr_b", 32'(mb_waitrequest), 32'd0);
        check("idle_s_read", 32'(s_read), 32'd0);
        tick();

        // Simultaneous reads after reset: A first, then B
        ma_read = 1'b1; ma_address = 30'h0000_0A10;
        mb_read = 1'b1; mb_address = 30'h0000_0B20;
        @(negedge clock);
        check("t1_a_read", 32'(s_read), 32'd1);
        check("t1_a_id", 32'(s_id), 32'd1);
        check("t1_a_addr", 32'(s_address), 32'h0000_0A10);
        check("t1_a_wr", 32'(ma_waitrequest), 32'd0);
        check("t1_b_wr", 32'(mb_waitrequest), 32'd1);
        tick();
        ma_read = 1'b0;
        @(negedge clock);
        check("t1_b_id", 32'(s_id), 32'd2);
        check("t1_b_addr", 32'(s_address), 32'h0000_0B20);
        check("t1_b_wr", 32'(mb_waitrequest), 32'd0);
        tick();
        mb_read = 1'b0;
        ret_burst(2'd1, 4);
        ret_burst(2'd2, 4);
        s_readdataid = 2'd3;
        @(negedge clock);
        check("t1_id3_rdv_a", 32'(ma_readdatavalid), 32'd0);
        check("t1_id3_rdv_b", 32'(mb_readdatavalid), 32'd0);
        tick();
        s_readdataid = 2'd0;

        // B write stalled three cycles while A waits
        mb_write = 1'b1; mb_address = 30'h0000_0C30;
        mb_writedata = 32'h1234_5678; mb_writedatamask = 4'hF;
        s_waitrequest = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("t2_write", 32'(s_write), 32'd1);
            check("t2_id", 32'(s_id), 32'd2);
            check("t2_wdata", s_writedata, 32'h1234_5678);
            check("t2_mask", 32'(s_writedatamask), 32'hF);
            check("t2_addr", 32'(s_address), 32'h0000_0C30);
            check("t2_wr_b", 32'(mb_waitrequest), 32'd1);
            if (i > 0) check("t2_wr_a", 32'(ma_waitrequest), 32'd1);
            tick();
            ma_read = 1'b1; ma_address = 30'h0000_0A40;
        end
        s_waitrequest = 1'b0;
        @(negedge clock);
        check("t2_acc_id", 32'(s_id), 32'd2);
        check("t2_acc_wr_b", 32'(mb_waitrequest), 32'd0);
        check("t2_acc_wr_a", 32'(ma_waitrequest), 32'd1);
        tick();
        mb_write = 1'b0;
        @(negedge clock);
        check("t2_a_id", 32'(s_id), 32'd1);
        check("t2_a_read", 32'(s_read), 32'd1);
        check("t2_a_addr", 32'(s_address), 32'h0000_0A40);
        check("t2_a_wr", 32'(ma_waitrequest), 32'd0);
        tick();
        ma_read = 1'b0;
        ret_burst(2'd1, 4);

        // Three back-to-back reads from A, third held by the outstanding limit
        ma_read = 1'b1; ma_address = 30'h0000_0100;
        @(negedge clock);
        check("t3_r0_wr", 32'(ma_waitrequest), 32'd0);
        tick();
        ma_address = 30'h0000_0104;
        @(negedge clock);
        check("t3_r1_wr", 32'(ma_waitrequest), 32'd0);
        tick();
        ma_address = 30'h0000_0108;
        for (int i = 0; i < 4; i++) begin
            s_readdataid = 2'd1; s_readdata = 32'hA300_0000 + 32'(i);
            @(negedge clock);
            check("t3_blk_wr", 32'(ma_waitrequest), 32'd1);
            check("t3_blk_read", 32'(s_read), 32'd0);
            check("t3_blk_rdv", 32'(ma_readdatavalid), 32'd1);
            tick();
        end
        s_readdataid = 2'd0;
        @(negedge clock);
        check("t3_r2_wr", 32'(ma_waitrequest), 32'd0);
        check("t3_r2_addr", 32'(s_address), 32'h0000_0108);
        tick();
        ma_read = 1'b0;
        ret_burst(2'd1, 8);

        // Read acceptance coinciding with the last word of an earlier burst
        ma_read = 1'b1; ma_address = 30'h0000_0200;
        @(negedge clock);
        check("t4_r0_wr", 32'(ma_waitrequest), 32'd0);
        tick();
        ma_read = 1'b0;
        ret_burst(2'd1, 3);
        ma_read = 1'b1; ma_address = 30'h0000_0204;
        s_readdataid = 2'd1; s_readdata = 32'hA400_0003;
        @(negedge clock);
        check("t4_coinc_wr", 32'(ma_waitrequest), 32'd0);
        check("t4_coinc_rdv", 32'(ma_readdatavalid), 32'd1);
        tick();
        s_readdataid = 2'd0; ma_address = 30'h0000_0208;
        @(negedge clock);
        check("t4_outst", 32'(u_dut.u_trk_a.r_outst), 32'd1);
        check("t4_next_wr", 32'(ma_waitrequest), 32'd0);
        tick();
        ma_address = 30'h0000_020C;
        @(negedge clock);
        check("t4_full_wr", 32'(ma_waitrequest), 32'd1);
        tick();
        ma_read = 1'b0;
        ret_burst(2'd1, 8);

        // Reset in the middle of a burst clears all bookkeeping
        ma_read = 1'b1; ma_address = 30'h0000_0300;
        @(negedge clock);
        check("t5_r0_wr", 32'(ma_waitrequest), 32'd0);
        tick();
        ma_read = 1'b0;
        ret_burst(2'd1, 2);
        rst = 1'b1;
        @(negedge clock);
        check("t5_rst_read", 32'(s_read), 32'd0);
        tick();
        rst = 1'b0; ma_read = 1'b1; ma_address = 30'h0000_0304;
        @(negedge clock);
        check("t5_outst", 32'(u_dut.u_trk_a.r_outst), 32'd0);
        check("t5_wcnt", 32'(u_dut.u_trk_a.r_wcnt), 32'd0);
        check("t5_r1_wr", 32'(ma_waitrequest), 32'd0);
        tick();
        ma_address = 30'h0000_0308;
        @(negedge clock);
        check("t5_r2_wr", 32'(ma_waitrequest), 32'd0);
        tick();
        ma_address = 30'h0000_030C;
        for (int i = 0; i < 4; i++) begin
            s_readdataid = 2'd1; s_readdata = 32'hA500_0000 + 32'(i);
            @(negedge clock);
            check("t5_blk_wr", 32'(ma_waitrequest), 32'd1);
            tick();
        end
        s_readdataid = 2'd0;
        @(negedge clock);
        check("t5_r3_wr", 32'(ma_waitrequest), 32'd0);
        tick();
        ma_read = 1'b0;
        ret_burst(2'd1, 8);

        // Continuous writes from both: strict alternation, B first since A won last
        ma_write = 1'b1; ma_address = 30'h0000_0400; ma_writedata = 32'hAAAA_0000; ma_writedatamask = 4'h3;
        mb_write = 1'b1; mb_address = 30'h0000_0500; mb_writedata = 32'hBBBB_0000; mb_writedatamask = 4'hC;
        exp_id = 2'd2;
        cnt_a  = 0;
        cnt_b  = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            check("t6_rr_id", 32'(s_id), 32'(exp_id));
            if (s_id == 2'd1) cnt_a++;
            if (s_id == 2'd2) cnt_b++;
            exp_id = (exp_id == 2'd1) ? 2'd2 : 2'd1;
            tick();
        end
        ma_write = 1'b0; mb_write = 1'b0;
        check("t6_cnt_a", 32'(cnt_a), 32'd50);
        check("t6_cnt_b", 32'(cnt_b), 32'd50);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
